vec_normalize_seq: RTL and testbench
====================================

Name: vec_normalize_seq

Overview:
- Iterative, area-lean, N-channel vector normalizer: out_i = x_i / sqrt(sum of x_j^2), fixed-point.
- Generalises the fully pipelined 4-channel normalizer datapath: channel count, width and fraction bits are parameters; adds valid/ready handshake with backpressure and a zero-vector flag.
- Uses one shared squarer/accumulator, a bit-serial restoring square root and a bit-serial restoring divider, sequenced by an FSM.
- Sits wherever throughput is low and area matters.

Parameters:
- NUM_CH, 4, number of vector channels (2..32).
- DATAWIDTH, 16, unsigned input width per channel.
- FRAC_BITS, 8, fractional bits of the inputs and outputs (8.8 at default).
- Derived localparam SUMW = 2*DATAWIDTH + clog2(NUM_CH): accumulator width (34).
- Derived localparam RW = ceil(SUMW/2): root width (17).
- Derived localparam DIVW = DATAWIDTH + FRAC_BITS: divide iterations per channel (24).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- i_valid, input, 1, input vector valid.
- i_ready, output, 1, block can accept a vector.
- i_data, input, NUM_CH*DATAWIDTH, packed unsigned channels; channel 0 in LSBs.
- o_valid, output, 1, result valid.
- o_ready, input, 1, downstream accepts the result.
- o_data, output, NUM_CH*(DATAWIDTH+1), packed normalized channels (FRAC_BITS fraction bits); channel 0 in LSBs.
- o_norm, output, RW, vector magnitude, FRAC_BITS fraction bits.
- o_zero, output, 1, input vector was all zero.
- o_busy, output, 1, FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, async): FSM goes to IDLE. o_valid, o_data, o_norm, o_zero and o_busy are 0; i_ready is 1 once reset is released. Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE -> SQUARE -> SQRT -> DIV -> DONE -> IDLE.
- IDLE:
  - i_ready = 1.
  - Accept edge = i_valid & i_ready; it latches i_data into a channel register file and clears the accumulator.
- SQUARE: NUM_CH cycles. Cycle c adds x_c*x_c (2*DATAWIDTH bits, zero-extended) into the SUMW-bit accumulator. The accumulator cannot overflow.
- After SQUARE:
  - sum == 0: go directly to DONE with o_zero = 1, o_data = 0 and o_norm = 0. SQRT and DIV are skipped and no divide by zero occurs.
  - Otherwise: go to SQRT.
- SQRT:
  - RW cycles of restoring integer square root, one root bit per cycle, MSB first.
  - Result root = floor(sqrt(sum)). Because the squares carry 2*FRAC_BITS fraction bits, root carries FRAC_BITS fraction bits.
- DIV:
  - NUM_CH channels in order 0..NUM_CH-1, DIVW cycles each.
  - Each channel is a restoring divide of (x_i << FRAC_BITS) by root; the quotient is truncated and the remainder discarded.
  - Since root >= x_i, the quotient is <= 2^FRAC_BITS and fits in DATAWIDTH+1 bits.
  - The quotient is written into its o_data slot when the channel completes.
- DONE:
  - o_valid = 1. o_data, o_norm and o_zero are held stable while o_valid & !o_ready.
  - Handshake edge (o_valid & o_ready) returns the FSM to IDLE; o_valid drops and i_ready rises on the following cycle.
  - A new vector is never accepted in the same cycle as result handoff.
- Outputs after handoff: o_data, o_norm and o_zero keep their last values until overwritten by the next result.
- Latency, accept edge to o_valid high:
  - Nonzero vector: L = NUM_CH + RW + NUM_CH*DIVW + 1 cycles (118 at defaults).
  - Zero vector: NUM_CH + 1 cycles (5 at defaults).
- Busy period: i_ready = 0 in every state except IDLE; i_valid is ignored and i_data is not sampled outside IDLE.
- o_busy = (state != IDLE).

Test Plan:
- Reset then idle: rst_n low mid-stream -> o_valid = 0, o_data = 0, i_ready = 1 after release; the in-flight result is discarded.
- 3-4-5 vector: N=4, i_data = {0,0,0x0400,0x0300} -> after 118 cycles o_norm = 0x00500, ch0 = 0x099, ch1 = 0x0CC, ch2 = ch3 = 0, o_zero = 0.
- Single channel: ch2 = 0x0200 (2.0), others 0 -> o_norm = 0x00200, ch2 = 0x100 (1.0), other channels 0. Also ch0 = 0x0001 -> o_norm = 1, ch0 = 0x100.
- Zero vector: all channels 0 -> o_valid after 5 cycles, o_zero = 1, o_data = 0, o_norm = 0.
- Backpressure: hold o_ready = 0 for 20 cycles in DONE -> o_valid and all outputs stable, i_ready = 0, i_valid pulses ignored. o_ready = 1 -> IDLE next cycle; the next accept is no earlier than one cycle later.
- Max input: all channels 0xFFFF -> o_norm = floor(sqrt(4*65535^2)) = 0x1FFFE, each channel = floor(65535*256/131070) = 0x080, no overflow.

Source files
------------

// File: rtl/vec_normalize_seq.sv
// -----------------------------------------------------------------------------
// vec_normalize_seq
//
// Iterative N-channel fixed-point vector normalizer:
//     o_data[i] = x_i / sqrt(sum_j x_j^2)
// One shared squarer/accumulator, a bit-serial restoring square root and a
// bit-serial restoring divider are sequenced by a small FSM. Intended for
// places where throughput is low and area matters.
//
// Parameters
//   NUM_CH     number of channels (2..32)
//   DATAWIDTH  unsigned input width per channel
//   FRAC_BITS  fraction bits of inputs and outputs
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   i_valid  input vector valid
//   i_ready  block can accept a vector (only in IDLE)
//   i_data   packed unsigned channels, channel 0 in LSBs
//   o_valid  result valid (held until o_ready)
//   o_ready  downstream accepts the result
//   o_data   packed normalized channels (DATAWIDTH+1 bits each), ch 0 in LSBs
//   o_norm   vector magnitude, FRAC_BITS fraction bits
//   o_zero   input vector was all zero
//   o_busy   FSM is not in IDLE
//
// Timing (accept edge to o_valid high)
//   nonzero vector: NUM_CH + RW + NUM_CH*DIVW + 1 cycles
//   zero vector   : NUM_CH + 1 cycles
// The trailing cycle is spent in DONE committing o_norm/o_zero (and clearing
// o_data for a zero vector) before o_valid is raised, so consumers never see
// a half-updated result.
// -----------------------------------------------------------------------------
module vec_normalize_seq #(
    parameter int NUM_CH    = 4,
    parameter int DATAWIDTH = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_valid,
    output logic                                  i_ready,
    input  logic [NUM_CH*DATAWIDTH-1:0]           i_data,
    output logic                                  o_valid,
    input  logic                                  o_ready,
    output logic [NUM_CH*(DATAWIDTH+1)-1:0]       o_data,
    output logic [(2*DATAWIDTH+$clog2(NUM_CH)+1)/2-1:0] o_norm,
    output logic                                  o_zero,
    output logic                                  o_busy
);

    // ---------------------------------------------------------------------
    // Derived sizes
    // ---------------------------------------------------------------------
    localparam int SUMW    = 2*DATAWIDTH + $clog2(NUM_CH);   // accumulator
    localparam int RW      = (SUMW + 1) / 2;                 // root width
    localparam int RADW    = 2*RW;                           // radicand, even width
    localparam int DIVW    = DATAWIDTH + FRAC_BITS;          // divide steps/channel
    localparam int OW      = DATAWIDTH + 1;                  // output channel width
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int CNT_MAX = (RW > DIVW) ? RW : DIVW;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQUARE = 3'd1,
        SQRT   = 3'd2,
        DIV    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [DATAWIDTH-1:0] x_reg    [NUM_CH];
    logic [OW-1:0]        odata_reg[NUM_CH];

    logic [CH_W-1:0]      ch_cnt_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [RADW-1:0]      acc_reg;      // sum of squares, then sqrt radicand shifter
    logic [RW-1:0]        root_reg;
    logic [RW:0]          rem_reg;      // shared sqrt / divide remainder
    logic [DIVW-1:0]      dvd_reg;
    logic [DIVW-1:0]      q_reg;
    logic                 zero_reg;
    logic                 o_valid_reg;
    logic [RW-1:0]        onorm_reg;
    logic                 ozero_reg;

    // ---------------------------------------------------------------------
    // Shared datapath (combinational)
    // ---------------------------------------------------------------------
    logic                 accept;
    logic                 ch_last;
    logic                 sqrt_last;
    logic                 div_last;
    logic                 first_step;
    logic [DATAWIDTH-1:0] x_cur;
    logic [2*DATAWIDTH-1:0] sq;
    logic [RADW-1:0]      acc_next;
    logic                 sum_zero;

    logic [RW:0]          rem_cur;
    logic [RW-1:0]        root_cur;
    logic [RW+2:0]        sq_rem_sh;
    logic [RW+2:0]        sq_trial;
    logic [RW+2:0]        sq_rem_diff;
    logic                 sq_ge;
    logic [RW-1:0]        root_next;
    logic [RW:0]          sq_rem_next;

    logic [DIVW-1:0]      dvd_cur;
    logic [RW+1:0]        dv_rem_sh;
    logic [RW+1:0]        dv_divisor;
    logic [RW+1:0]        dv_rem_diff;
    logic                 dv_ge;
    logic [RW:0]          dv_rem_next;
    logic [DIVW-1:0]      q_cur;
    logic [DIVW-1:0]      q_next;

    assign accept     = i_valid & i_ready;
    assign ch_last    = (ch_cnt_reg == CH_W'(NUM_CH - 1));
    assign sqrt_last  = (bit_cnt_reg == CNT_W'(RW - 1));
    assign div_last   = (bit_cnt_reg == CNT_W'(DIVW - 1));
    // Sqrt and each divide start from a clean remainder/partial result, so
    // the counter at zero selects constants instead of stale register state.
    assign first_step = (bit_cnt_reg == '0);

    // Squarer + accumulator
    assign x_cur    = x_reg[ch_cnt_reg];
    assign sq       = {{DATAWIDTH{1'b0}}, x_cur} * {{DATAWIDTH{1'b0}}, x_cur};
    assign acc_next = acc_reg + {{(RADW-2*DATAWIDTH){1'b0}}, sq};
    assign sum_zero = (acc_next == '0);

    assign rem_cur  = first_step ? '0 : rem_reg;
    assign root_cur = first_step ? '0 : root_reg;

    // Restoring square root: bring down two radicand bits, try (root<<2)|1.
    assign sq_rem_sh   = {rem_cur, acc_reg[RADW-1 -: 2]};
    assign sq_trial    = {1'b0, root_cur, 2'b01};
    assign sq_ge       = (sq_rem_sh >= sq_trial);
    assign sq_rem_diff = sq_ge ? (sq_rem_sh - sq_trial) : sq_rem_sh;
    // Remainder never exceeds 2*root, so RW+1 bits hold it.
    assign sq_rem_next = sq_rem_diff[RW:0];
    assign root_next   = {root_cur[RW-2:0], sq_ge};

    // Restoring divide of (x << FRAC_BITS) by root, one quotient bit/cycle.
    assign dvd_cur     = first_step ? (DIVW'(x_cur) << FRAC_BITS) : dvd_reg;
    assign q_cur       = first_step ? '0 : q_reg;
    assign dv_rem_sh   = {rem_cur, dvd_cur[DIVW-1]};
    assign dv_divisor  = {2'b00, root_reg};
    assign dv_ge       = (dv_rem_sh >= dv_divisor);
    assign dv_rem_diff = dv_ge ? (dv_rem_sh - dv_divisor) : dv_rem_sh;
    // Divide remainder is always below root, well inside RW+1 bits.
    assign dv_rem_next = dv_rem_diff[RW:0];
    assign q_next      = {q_cur[DIVW-2:0], dv_ge};

    // Bits that are provably zero after the width analysis above.
    logic unused_bits;
    assign unused_bits = ^{sq_rem_diff[RW+2:RW+1], dv_rem_diff[RW+1], q_cur[DIVW-1]};

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        i_ready    = 1'b0;
        o_busy     = 1'b1;
        unique case (state_reg)
            IDLE: begin
                i_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    state_next = SQUARE;
                end
            end
            SQUARE: begin
                if (ch_last) begin
                    // All-zero input bypasses the root/divide to avoid x/0.
                    state_next = sum_zero ? DONE : SQRT;
                end
            end
            SQRT: begin
                if (sqrt_last) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (div_last && ch_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (o_valid_reg && o_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Sequencing registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            acc_reg     <= '0;
            root_reg    <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            q_reg       <= '0;
            zero_reg    <= 1'b0;
            o_valid_reg <= 1'b0;
            onorm_reg   <= '0;
            ozero_reg   <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg     <= '0;
                        ch_cnt_reg  <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                SQUARE: begin
                    acc_reg <= acc_next;
                    if (ch_last) begin
                        zero_reg    <= sum_zero;
                        ch_cnt_reg  <= '0;
                        bit_cnt_reg <= '0;
                    end else begin
                        ch_cnt_reg  <= ch_cnt_reg + CH_W'(1);
                    end
                end
                SQRT: begin
                    acc_reg  <= {acc_reg[RADW-3:0], 2'b00};
                    root_reg <= root_next;
                    rem_reg  <= sq_rem_next;
                    bit_cnt_reg <= sqrt_last ? '0 : bit_cnt_reg + CNT_W'(1);
                end
                DIV: begin
                    dvd_reg <= {dvd_cur[DIVW-2:0], 1'b0};
                    q_reg   <= q_next;
                    rem_reg <= dv_rem_next;
                    if (div_last) begin
                        bit_cnt_reg <= '0;
                        if (!ch_last) begin
                            ch_cnt_reg <= ch_cnt_reg + CH_W'(1);
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!o_valid_reg) begin
                        // Commit cycle: load the summary outputs, then present.
                        o_valid_reg <= 1'b1;
                        onorm_reg   <= zero_reg ? '0 : root_reg;
                        ozero_reg   <= zero_reg;
                    end else if (o_ready) begin
                        o_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    o_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Channel register file, sampled only on the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                x_reg[i] <= i_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Output channel slots: written as each channel's divide completes,
    // cleared in the commit cycle of a zero vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                odata_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state_reg == DIV && div_last && ch_cnt_reg == CH_W'(i)) begin
                    odata_reg[i] <= q_next[OW-1:0];
                end else if (state_reg == DONE && !o_valid_reg && zero_reg) begin
                    odata_reg[i] <= '0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pack
            assign o_data[gi*OW +: OW] = odata_reg[gi];
        end
    endgenerate

    assign o_valid = o_valid_reg;
    assign o_norm  = onorm_reg;
    assign o_zero  = ozero_reg;

endmodule

// File: tb/tb_vec_normalize_seq.sv
// -----------------------------------------------------------------------------
// tb_vec_normalize_seq
//
// Directed table of vectors with hand-computed norms, quotients and latencies,
// followed by hand-written sequences for backpressure and mid-operation reset.
// One line is printed per transaction.
// -----------------------------------------------------------------------------
module tb_vec_normalize_seq;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;
    localparam int OW     = DW + 1;
    localparam int RW     = 17;
    localparam int LAT_NZ = 118;
    localparam int LAT_Z  = 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_valid = 1'b0;
    logic                   i_ready;
    logic [NUM_CH*DW-1:0]   i_data = '0;
    logic                   o_valid;
    logic                   o_ready = 1'b1;
    logic [NUM_CH*OW-1:0]   o_data;
    logic [RW-1:0]          o_norm;
    logic                   o_zero;
    logic                   o_busy;

    vec_normalize_seq #(
        .NUM_CH   (NUM_CH),
        .DATAWIDTH(DW),
        .FRAC_BITS(8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_norm (o_norm),
        .o_zero (o_zero),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH*DW-1:0] din;
        logic [NUM_CH*OW-1:0] dout;
        logic [RW-1:0]        norm;
        logic                 zero;
        int                   lat;
    } vec_t;

    vec_t vecs[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after the accept edge; waits (bounded) for o_valid and checks
    // latency plus all result fields. o_ready is left to the caller.
    task automatic collect(input string tag, input vec_t v);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (o_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cnt++;
            end
        end
        chk({tag, "_latency"}, seen ? cnt : 9999, v.lat);
        chk({tag, "_norm"},  o_norm,  v.norm);
        chk({tag, "_data"},  o_data,  v.dout);
        chk({tag, "_zero"},  o_zero,  v.zero);
        chk({tag, "_iready_busy"}, i_ready, 0);
        $display("[TB] %s in=%h norm=%h data=%h zero=%b lat=%0d", tag, v.din, o_norm, o_data, o_zero, cnt);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        chk({tag, "_ready_before"}, i_ready, 1);
        i_data  = v.din;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_data  = '0;
        chk({tag, "_busy_after_accept"}, o_busy, 1);
        collect(tag, v);
        o_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, o_valid, 0);
        chk({tag, "_ready_rise"}, i_ready, 1);
    endtask

    initial begin
        // 3-4-5
        vecs[0] = '{din: {16'h0000, 16'h0000, 16'h0400, 16'h0300},
                    dout: {17'h0, 17'h0, 17'h0CC, 17'h099}, norm: 17'h00500, zero: 1'b0, lat: LAT_NZ};
        // single channel 2.0 on ch2
        vecs[1] = '{din: {16'h0000, 16'h0200, 16'h0000, 16'h0000},
                    dout: {17'h0, 17'h100, 17'h0, 17'h0}, norm: 17'h00200, zero: 1'b0, lat: LAT_NZ};
        // smallest nonzero: ch0 = 1 LSB
        vecs[2] = '{din: {16'h0000, 16'h0000, 16'h0000, 16'h0001},
                    dout: {17'h0, 17'h0, 17'h0, 17'h100}, norm: 17'h00001, zero: 1'b0, lat: LAT_NZ};
        // zero vector (follows a nonzero result, so o_data must be cleared)
        vecs[3] = '{din: '0, dout: '0, norm: '0, zero: 1'b1, lat: LAT_Z};
        // full scale on all channels: root = 2*65535, each = 128
        vecs[4] = '{din: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                    dout: {17'h080, 17'h080, 17'h080, 17'h080}, norm: 17'h1FFFE, zero: 1'b0, lat: LAT_NZ};
        // all 1.0: norm 2.0, each 0.5
        vecs[5] = '{din: {16'h0100, 16'h0100, 16'h0100, 16'h0100},
                    dout: {17'h080, 17'h080, 17'h080, 17'h080}, norm: 17'h00200, zero: 1'b0, lat: LAT_NZ};
        // 5-12-13 on ch1/ch3: 5/13 -> 0x62, 12/13 -> 0xEC
        vecs[6] = '{din: {16'h0C00, 16'h0000, 16'h0500, 16'h0000},
                    dout: {17'h0EC, 17'h0, 17'h062, 17'h0}, norm: 17'h00D00, zero: 1'b0, lat: LAT_NZ};
        // 1,1: root truncated to 0x16A, each 65536/362 -> 0xB5
        vecs[7] = '{din: {16'h0000, 16'h0000, 16'h0100, 16'h0100},
                    dout: {17'h0, 17'h0, 17'h0B5, 17'h0B5}, norm: 17'h0016A, zero: 1'b0, lat: LAT_NZ};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data",  o_data,  0);
        chk("rst_norm",  o_norm,  0);
        chk("rst_zero",  o_zero,  0);
        chk("rst_busy",  o_busy,  0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready_after_release", i_ready, 1);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------------- backpressure ----------------
        o_ready = 1'b0;
        i_data  = vecs[0].din;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        collect("bp", vecs[0]);
        for (int c = 0; c < 20; c++) begin
            i_valid = c[0];
            i_data  = {4{16'h1234}};
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", c),
                {o_valid, i_ready, o_busy, o_zero, o_norm, o_data},
                {1'b1, 1'b0, 1'b1, 1'b0, vecs[0].norm, vecs[0].dout});
        end
        // Release with i_valid asserted: it must not be taken at the handoff edge.
        i_data  = vecs[5].din;
        i_valid = 1'b1;
        o_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_valid", o_valid, 0);
        chk("bp_handoff_idle",  o_busy,  0);
        chk("bp_handoff_ready", i_ready, 1);
        chk("bp_data_kept",     o_data,  vecs[0].dout);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("bp_next_accept", o_busy, 1);
        collect("bp_next", vecs[5]);
        @(posedge clk); #1;
        chk("bp_next_valid_drop", o_valid, 0);

        // ---------------- reset mid-operation ----------------
        i_data  = vecs[4].din;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_data",  o_data,  0);
        chk("midrst_norm",  o_norm,  0);
        chk("midrst_busy",  o_busy,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", i_ready, 1);
        begin
            bit any_valid;
            any_valid = 1'b0;
            for (int k = 0; k < 150; k++) begin
                @(posedge clk); #1;
                if (o_valid) any_valid = 1'b1;
            end
            chk("midrst_no_result", any_valid, 0);
            $display("[TB] midrst aborted, o_valid seen=%b", any_valid);
        end

        // recovery after reset
        run_vec("recover", vecs[6]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
